// File: rtl/demux_1a2_cond.sv
// demux_1a2_cond -- 1:2 demultiplexer. This is the receive end of the 2:1 interleaving mux.
//
// The input is one time-interleaved byte stream: a lane 0 byte, then a lane 1 byte,
// on alternate clk cycles. The block splits it back into two aligned lanes. Both lanes
// update together once every two clk cycles, and each lane has its own valid.
//
// Alignment: the first valid byte seen after reset is taken as lane 0. From that point
// the slot counter runs freely until the next reset.
//
// Ports:
//   clk          input stream clock (one byte per cycle)
//   reset        asynchronous active-low reset
//   data_in      interleaved byte stream
//   valid_in     data_in is valid this cycle
//   data_out_0/1 lane bytes (each holds its last valid value)
//   valid_out_0/1 lane valids for the current frame
//   frame_stb    one-cycle pulse on the edge that loads a new frame
//   aligned      high once the stream has been aligned (RUN state)
//   cnt_0/1      (only with DEMUX_LANE_CNT_EN) 8-bit wrapping counts of valid lane frames
//
// Optional feature macro: DEMUX_LANE_CNT_EN
module demux_1a2_cond #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic              valid_out_0,
  output logic              valid_out_1,
  output logic              frame_stb,
  output logic              aligned
`ifdef DEMUX_LANE_CNT_EN
  ,
  output logic [7:0]        cnt_0,
  output logic [7:0]        cnt_1
`endif
);

  typedef enum logic {WAIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              slot_q, slot_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic              hold_v0_q, hold_v0_d;
  logic [DATA_W-1:0] data_out_0_q, data_out_0_d;
  logic [DATA_W-1:0] data_out_1_q, data_out_1_d;
  logic              valid_out_0_q, valid_out_0_d;
  logic              valid_out_1_q, valid_out_1_d;
  logic              frame_stb_q, frame_stb_d;
  logic              aligned_q, aligned_d;
`ifdef DEMUX_LANE_CNT_EN
  logic [7:0]        cnt_0_q, cnt_0_d;
  logic [7:0]        cnt_1_q, cnt_1_d;
`endif

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    hold0_d       = hold0_q;
    hold_v0_d     = hold_v0_q;
    data_out_0_d  = data_out_0_q;
    data_out_1_d  = data_out_1_q;
    valid_out_0_d = valid_out_0_q;
    valid_out_1_d = valid_out_1_q;
    frame_stb_d   = frame_stb_q;
    aligned_d     = aligned_q;
`ifdef DEMUX_LANE_CNT_EN
    cnt_0_d       = cnt_0_q;
    cnt_1_d       = cnt_1_q;
`endif
    case (state_q)
      WAIT: begin
        // The first valid byte defines the lane 0 slot.
        if (valid_in) begin
          hold0_d   = data_in;
          hold_v0_d = 1'b1;
          slot_d    = 1'b1;
          aligned_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // The slot advances every edge. Invalid bytes do not stall it, so lane alignment is kept.
        slot_d = ~slot_q;
        if (!slot_q) begin
          if (valid_in) hold0_d = data_in;
          hold_v0_d   = valid_in;
          frame_stb_d = 1'b0;
        end else begin
          valid_out_0_d = hold_v0_q;
          if (hold_v0_q) data_out_0_d = hold0_q;
          valid_out_1_d = valid_in;
          if (valid_in) data_out_1_d = data_in;
          frame_stb_d   = 1'b1;
`ifdef DEMUX_LANE_CNT_EN
          if (hold_v0_q) cnt_0_d = cnt_0_q + 8'd1;
          if (valid_in)  cnt_1_d = cnt_1_q + 8'd1;
`endif
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= WAIT;
      slot_q        <= 1'b0;
      hold0_q       <= '0;
      hold_v0_q     <= 1'b0;
      data_out_0_q  <= '0;
      data_out_1_q  <= '0;
      valid_out_0_q <= 1'b0;
      valid_out_1_q <= 1'b0;
      frame_stb_q   <= 1'b0;
      aligned_q     <= 1'b0;
`ifdef DEMUX_LANE_CNT_EN
      cnt_0_q       <= 8'd0;
      cnt_1_q       <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      hold0_q       <= hold0_d;
      hold_v0_q     <= hold_v0_d;
      data_out_0_q  <= data_out_0_d;
      data_out_1_q  <= data_out_1_d;
      valid_out_0_q <= valid_out_0_d;
      valid_out_1_q <= valid_out_1_d;
      frame_stb_q   <= frame_stb_d;
      aligned_q     <= aligned_d;
`ifdef DEMUX_LANE_CNT_EN
      cnt_0_q       <= cnt_0_d;
      cnt_1_q       <= cnt_1_d;
`endif
    end
  end

  assign data_out_0  = data_out_0_q;
  assign data_out_1  = data_out_1_q;
  assign valid_out_0 = valid_out_0_q;
  assign valid_out_1 = valid_out_1_q;
  assign frame_stb   = frame_stb_q;
  assign aligned     = aligned_q;
`ifdef DEMUX_LANE_CNT_EN
  assign cnt_0       = cnt_0_q;
  assign cnt_1       = cnt_1_q;
`endif

endmodule

// File: tb/tb_demux_1a2_cond.sv
// Directed bench for demux_1a2_cond. Inputs are driven 1 time unit after each rising
// edge. Outputs are sampled 1 time unit after the edge that produced them.
module tb_demux_1a2_cond;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1, frame_stb, aligned;
`ifdef DEMUX_LANE_CNT_EN
  logic [7:0] cnt_0, cnt_1;
`endif

  int nvec = 0;
  int nerr = 0;

  demux_1a2_cond #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
    .frame_stb(frame_stb), .aligned(aligned)
`ifdef DEMUX_LANE_CNT_EN
    , .cnt_0(cnt_0), .cnt_1(cnt_1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check the full output set.
  task automatic chk_out(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                         input logic v0, input logic v1, input logic stb, input logic al);
    chk({tag, ".d0"}, {24'd0, data_out_0}, {24'd0, d0});
    chk({tag, ".d1"}, {24'd0, data_out_1}, {24'd0, d1});
    chk({tag, ".v0"}, {31'd0, valid_out_0}, {31'd0, v0});
    chk({tag, ".v1"}, {31'd0, valid_out_1}, {31'd0, v1});
    chk({tag, ".stb"}, {31'd0, frame_stb}, {31'd0, stb});
    chk({tag, ".al"}, {31'd0, aligned}, {31'd0, al});
  endtask

  // Present one byte, clock it in, and settle for sampling.
  task automatic step(input logic [7:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; data_in = 8'h00; valid_in = 1'b0;
    // 1. reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 8'h00, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(8'h5A, 1'b0);
      chk_out("idle", 8'h00, 8'h00, 0, 0, 0, 0);
    end

    // 2. alignment and basic split
    step(8'hA0, 1'b1);
    chk_out("align", 8'h00, 8'h00, 0, 0, 0, 1);
    step(8'hB0, 1'b1);
    chk_out("frm1", 8'hA0, 8'hB0, 1, 1, 1, 1);
    step(8'hA1, 1'b1);
    chk_out("frm1b", 8'hA0, 8'hB0, 1, 1, 0, 1);
    step(8'hB1, 1'b1);
    chk_out("frm2", 8'hA1, 8'hB1, 1, 1, 1, 1);

    // 3. invalid lane 1
    step(8'h11, 1'b1);
    step(8'h22, 1'b1);
    chk_out("frm3", 8'h11, 8'h22, 1, 1, 1, 1);
    step(8'h33, 1'b1);
    step(8'hFF, 1'b0);
    chk_out("inv1", 8'h33, 8'h22, 1, 0, 1, 1);

    // 4. both lanes invalid for two frames
    step(8'hEE, 1'b0);
    chk_out("inv2a", 8'h33, 8'h22, 1, 0, 0, 1);
    step(8'hDD, 1'b0);
    chk_out("inv2b", 8'h33, 8'h22, 0, 0, 1, 1);
    step(8'hCC, 1'b0);
    chk_out("inv2c", 8'h33, 8'h22, 0, 0, 0, 1);
    step(8'hBB, 1'b0);
    chk_out("inv2d", 8'h33, 8'h22, 0, 0, 1, 1);
    step(8'h44, 1'b1);
    step(8'h55, 1'b1);
    chk_out("realign", 8'h44, 8'h55, 1, 1, 1, 1);

    // 5. reset mid-frame (lane 0 captured, slot 1 edge not yet taken)
    step(8'h66, 1'b1);
    reset = 1'b0;
    #1;
    chk_out("asyncrst", 8'h00, 8'h00, 0, 0, 0, 0);
    #3;
    reset = 1'b1;
    step(8'h99, 1'b0);
    step(8'h98, 1'b0);
    chk_out("postrst", 8'h00, 8'h00, 0, 0, 0, 0);
    step(8'h77, 1'b1);
    chk_out("realign2", 8'h00, 8'h00, 0, 0, 0, 1);
    step(8'h88, 1'b1);
    chk_out("frm5", 8'h77, 8'h88, 1, 1, 1, 1);

`ifdef DEMUX_LANE_CNT_EN
    // 6. lane counters: 260 frames, lane 1 valid on even frames only
    reset = 1'b0;
    #2;
    chk("cnt0rst", {24'd0, cnt_0}, 32'd0);
    chk("cnt1rst", {24'd0, cnt_1}, 32'd0);
    reset = 1'b1;
    step(8'h00, 1'b0);
    chk("cnt0wait", {24'd0, cnt_0}, 32'd0);
    for (int f = 0; f < 260; f++) begin
      step(8'(f), 1'b1);
      step(8'(f + 1), (f % 2) == 0);
    end
    chk("cnt0", {24'd0, cnt_0}, 32'd4);
    chk("cnt1", {24'd0, cnt_1}, 32'd130);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
